// File: rtl/hilo_mult_ctrl.sv
// HI/LO owner and shift-add multiply sequencer: one multiplier bit per RUN cycle,
// MTHI/MTLO writes while idle, and stall/busy indications for the hazard unit.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_IDLE   | no multiply in flight; MTHI/MTLO accepted; start launches
// S_RUN    | one shift-add iteration per cycle, WIDTH iterations total
// S_COMMIT | product (sign-corrected) written to HI/LO at the closing edge
module hilo_mult_ctrl #(
    parameter int WIDTH     = 32,
    parameter bit ZERO_SKIP = 1'b1
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             start_i,
    input  logic             is_signed_i,
    input  logic [WIDTH-1:0] op_a_i,
    input  logic [WIDTH-1:0] op_b_i,
    input  logic             mthi_i,
    input  logic             mtlo_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             flush_i,
    input  logic             rd_hilo_i,
    output logic             busy_o,
    output logic             stall_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    state_t               state_q;
    logic [2*WIDTH-1:0]   mcand_q;
    logic [2*WIDTH-1:0]   prod_q;
    logic [WIDTH-1:0]     mplier_q;
    logic [WIDTH-1:0]     hi_q;
    logic [WIDTH-1:0]     lo_q;
    logic [CW-1:0]        count_q;
    logic                 neg_q;
    logic                 done_q;

    logic [WIDTH-1:0]     a_mag_d;
    logic [WIDTH-1:0]     b_mag_d;
    logic                 neg_d;
    logic                 zero_op_d;
    logic                 launch_d;
    logic                 write_ok_d;
    logic                 last_iter_d;
    logic [2*WIDTH-1:0]   prod_d;
    logic [2*WIDTH-1:0]   result_d;

    // Negating the most-negative value wraps back to itself, which is the
    // correct unsigned magnitude, so no special case is needed.
    always_comb begin
        a_mag_d     = (is_signed_i && op_a_i[WIDTH-1]) ? -op_a_i : op_a_i;
        b_mag_d     = (is_signed_i && op_b_i[WIDTH-1]) ? -op_b_i : op_b_i;
        neg_d       = is_signed_i & (op_a_i[WIDTH-1] ^ op_b_i[WIDTH-1]);
        zero_op_d   = ZERO_SKIP && ((op_a_i == '0) || (op_b_i == '0));
        launch_d    = (state_q == S_IDLE) && start_i && !flush_i;
        write_ok_d  = (state_q == S_IDLE) && !start_i && !flush_i;
        last_iter_d = (count_q == CW'(WIDTH - 1));
        prod_d      = mplier_q[0] ? (prod_q + mcand_q) : prod_q;
        result_d    = neg_q ? -prod_q : prod_q;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q  <= S_IDLE;
            mcand_q  <= '0;
            prod_q   <= '0;
            mplier_q <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            count_q  <= '0;
            neg_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (launch_d) begin
                        mcand_q  <= {{WIDTH{1'b0}}, a_mag_d};
                        mplier_q <= b_mag_d;
                        prod_q   <= '0;
                        count_q  <= '0;
                        if (zero_op_d) begin
                            neg_q   <= 1'b0;
                            state_q <= S_COMMIT;
                            done_q  <= 1'b1;
                        end else begin
                            neg_q   <= neg_d;
                            state_q <= S_RUN;
                        end
                    end else begin
                        if (write_ok_d && mthi_i) hi_q <= wdata_i;
                        if (write_ok_d && mtlo_i) lo_q <= wdata_i;
                    end
                end
                S_RUN: begin
                    if (flush_i) begin
                        state_q <= S_IDLE;
                    end else begin
                        prod_q   <= prod_d;
                        mcand_q  <= mcand_q << 1;
                        mplier_q <= mplier_q >> 1;
                        count_q  <= count_q + CW'(1);
                        if (last_iter_d) begin
                            state_q <= S_COMMIT;
                            done_q  <= 1'b1;
                        end
                    end
                end
                // Flush is deliberately ignored here: the result is already architectural.
                S_COMMIT: begin
                    hi_q    <= result_d[2*WIDTH-1:WIDTH];
                    lo_q    <= result_d[WIDTH-1:0];
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy_o  = (state_q != S_IDLE);
    assign stall_o = busy_o & (rd_hilo_i | mthi_i | mtlo_i);
    assign done_o  = done_q;
    assign hi_o    = hi_q;
    assign lo_o    = lo_q;

endmodule
